// File: rtl/wshb_arb_pkg.sv
// rtl/wshb_arb_pkg.sv - shared types and burst tags for the SDRAM Wishbone arbiter
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wshb_arb_watchdog.sv
// rtl/wshb_arb_watchdog.sv - counts unanswered owner strobes, flags the cycle that hits TIMEOUT
module wshb_arb_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    assign expire = inc && (count == CW'(TIMEOUT - 1));

    // Expiry restarts the count so a re-granted master gets a fresh window.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count <= '0;
        end else if (clr || expire) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wshb_sdram_arbiter.sv
// rtl/wshb_sdram_arbiter.sv - round-robin two-master Wishbone arbiter in front of the SDRAM slave
module wshb_sdram_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    m0_cyc,
    input  logic                    m0_stb,
    input  logic                    m0_we,
    input  logic [ADDR_W-1:0]       m0_adr,
    input  logic [8*DATA_BYTES-1:0] m0_dat_ms,
    input  logic [DATA_BYTES-1:0]   m0_sel,
    input  logic [2:0]              m0_cti,
    input  logic [1:0]              m0_bte,
    output logic [8*DATA_BYTES-1:0] m0_dat_sm,
    output logic                    m0_ack,
    output logic                    m0_err,
    output logic                    m0_rty,
    input  logic                    m1_cyc,
    input  logic                    m1_stb,
    input  logic                    m1_we,
    input  logic [ADDR_W-1:0]       m1_adr,
    input  logic [8*DATA_BYTES-1:0] m1_dat_ms,
    input  logic [DATA_BYTES-1:0]   m1_sel,
    input  logic [2:0]              m1_cti,
    input  logic [1:0]              m1_bte,
    output logic [8*DATA_BYTES-1:0] m1_dat_sm,
    output logic                    m1_ack,
    output logic                    m1_err,
    output logic                    m1_rty,
    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [ADDR_W-1:0]       s_adr,
    output logic [8*DATA_BYTES-1:0] s_dat_ms,
    output logic [DATA_BYTES-1:0]   s_sel,
    output logic [2:0]              s_cti,
    output logic [1:0]              s_bte,
    input  logic [8*DATA_BYTES-1:0] s_dat_sm,
    input  logic                    s_ack,
    input  logic                    s_err,
    input  logic                    s_rty,
    output logic [1:0]              grant
);

    arb_state_t state;
    logic       last_owner;
    logic       own0, own1;
    logic       own_cyc, own_stb;
    logic       term, wd_inc, wd_expire;

    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);
    assign term = s_ack | s_err | s_rty;

    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        s_cti    = '0;
        s_bte    = '0;
        if (own0) begin
            own_cyc  = m0_cyc;
            own_stb  = m0_stb;
            s_we     = m0_we;
            s_adr    = m0_adr;
            s_dat_ms = m0_dat_ms;
            s_sel    = m0_sel;
            s_cti    = m0_cti;
            s_bte    = m0_bte;
        end else if (own1) begin
            own_cyc  = m1_cyc;
            own_stb  = m1_stb;
            s_we     = m1_we;
            s_adr    = m1_adr;
            s_dat_ms = m1_dat_ms;
            s_sel    = m1_sel;
            s_cti    = m1_cti;
            s_bte    = m1_bte;
        end
    end

    assign wd_inc = own_cyc & own_stb & ~term;

    wshb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (~wd_inc),
        .inc       (wd_inc),
        .expire    (wd_expire)
    );

    // The owner's cyc gates the slave strobe so a dropped cycle ends on the slave immediately.
    assign s_cyc = own_cyc & ~wd_expire;
    assign s_stb = own_cyc & own_stb & ~wd_expire;

    assign m0_dat_sm = own0 ? s_dat_sm : '0;
    assign m0_ack    = own0 & s_ack;
    assign m0_err    = own0 & (s_err | wd_expire);
    assign m0_rty    = own0 & s_rty;
    assign m1_dat_sm = own1 ? s_dat_sm : '0;
    assign m1_ack    = own1 & s_ack;
    assign m1_err    = own1 & (s_err | wd_expire);
    assign m1_rty    = own1 & s_rty;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            grant      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc && (!m1_cyc || last_owner)) begin
                        state <= OWN0;
                        grant <= 2'b01;
                    end else if (m1_cyc) begin
                        state <= OWN1;
                        grant <= 2'b10;
                    end
                end
                OWN0: begin
                    if (wd_expire || !m0_cyc) begin
                        last_owner <= 1'b0;
                        if (m1_cyc && !wd_expire) begin
                            state <= OWN1;
                            grant <= 2'b10;
                        end else begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end
                end
                OWN1: begin
                    if (wd_expire || !m1_cyc) begin
                        last_owner <= 1'b1;
                        if (m0_cyc && !wd_expire) begin
                            state <= OWN0;
                            grant <= 2'b01;
                        end else begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// tb/tb_wshb_sdram_arbiter.sv - directed and randomized checks of the arbiter against a behavioural model
module tb_wshb_sdram_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic [2:0]  m_cti [2];
    logic [1:0]  m_bte [2];
    logic [31:0] s_dat_sm;
    logic        s_ack, s_err, s_rty;

    logic [31:0] m0_dat_sm, m1_dat_sm, s_adr, s_dat_ms;
    logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;
    logic [1:0]  grant;

    int checks = 0;
    int failures = 0;

    int mdl_own;
    int mdl_last;
    int mdl_cnt;

    always #5 clk = ~clk;

    wshb_sdram_arbiter #(.ADDR_W(32), .DATA_BYTES(4), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_adr(m_adr[0]),
        .m0_dat_ms(m_dat[0]), .m0_sel(m_sel[0]), .m0_cti(m_cti[0]), .m0_bte(m_bte[0]),
        .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
        .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_adr(m_adr[1]),
        .m1_dat_ms(m_dat[1]), .m1_sel(m_sel[1]), .m1_cti(m_cti[1]), .m1_bte(m_bte[1]),
        .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms),
        .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_dat_sm(s_dat_sm), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
        .grant(grant)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_own  = -1;
        mdl_last = 1;
        mdl_cnt  = 0;
    endtask

    // Watchdog view of the current cycle: is an owner strobe going unanswered, and is it the last allowed one.
    task automatic model_terms(output bit inc, output bit expire);
        bit term;
        term   = s_ack | s_err | s_rty;
        inc    = (mdl_own >= 0) && m_cyc[mdl_own] && m_stb[mdl_own] && !term;
        expire = inc && (mdl_cnt == TIMEOUT - 1);
    endtask

    task automatic compare();
        bit inc, ex, own_cyc;
        logic [31:0] dat_exp [2];
        logic        ack_exp [2];
        logic        err_exp [2];
        logic        rty_exp [2];
        int o;
        model_terms(inc, ex);
        o = mdl_own;
        own_cyc = (o >= 0) && m_cyc[o];
        for (int i = 0; i < 2; i++) begin
            dat_exp[i] = (o == i) ? s_dat_sm : 32'h0;
            ack_exp[i] = (o == i) && s_ack;
            err_exp[i] = (o == i) && (s_err || ex);
            rty_exp[i] = (o == i) && s_rty;
        end
        check("s_cyc", 64'(s_cyc), 64'(own_cyc && !ex));
        check("s_stb", 64'(s_stb), 64'(own_cyc && m_stb[o < 0 ? 0 : o] && !ex));
        check("s_we", 64'(s_we), 64'((o >= 0) ? m_we[o] : 1'b0));
        check("s_adr", 64'(s_adr), 64'((o >= 0) ? m_adr[o] : 32'h0));
        check("s_dat_ms", 64'(s_dat_ms), 64'((o >= 0) ? m_dat[o] : 32'h0));
        check("s_sel", 64'(s_sel), 64'((o >= 0) ? m_sel[o] : 4'h0));
        check("s_cti", 64'(s_cti), 64'((o >= 0) ? m_cti[o] : 3'h0));
        check("s_bte", 64'(s_bte), 64'((o >= 0) ? m_bte[o] : 2'h0));
        check("grant", 64'(grant), 64'((o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00));
        check("m0_dat_sm", 64'(m0_dat_sm), 64'(dat_exp[0]));
        check("m1_dat_sm", 64'(m1_dat_sm), 64'(dat_exp[1]));
        check("m0_ack", 64'(m0_ack), 64'(ack_exp[0]));
        check("m1_ack", 64'(m1_ack), 64'(ack_exp[1]));
        check("m0_err", 64'(m0_err), 64'(err_exp[0]));
        check("m1_err", 64'(m1_err), 64'(err_exp[1]));
        check("m0_rty", 64'(m0_rty), 64'(rty_exp[0]));
        check("m1_rty", 64'(m1_rty), 64'(rty_exp[1]));
    endtask

    task automatic model_step();
        bit inc, ex;
        int o;
        model_terms(inc, ex);
        o = mdl_own;
        if (!rst_n) begin
            model_reset();
        end else if (o < 0) begin
            if (m_cyc[0] && m_cyc[1]) mdl_own = (mdl_last == 1) ? 0 : 1;
            else if (m_cyc[0])        mdl_own = 0;
            else if (m_cyc[1])        mdl_own = 1;
            mdl_cnt = 0;
        end else if (ex) begin
            mdl_last = o;
            mdl_own  = -1;
            mdl_cnt  = 0;
        end else if (!m_cyc[o]) begin
            mdl_last = o;
            mdl_own  = m_cyc[1 - o] ? 1 - o : -1;
            mdl_cnt  = 0;
        end else begin
            mdl_cnt = inc ? mdl_cnt + 1 : 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_master(input int i, input bit cyc, input bit stb, input logic [2:0] cti);
        m_cyc[i] = cyc;
        m_stb[i] = stb;
        m_cti[i] = cti;
    endtask

    initial begin
        bit dead;
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 0; m_stb[i] = 0; m_we[i] = 0; m_adr[i] = 32'h1000 * (i + 1);
            m_dat[i] = 32'hA5A5_0000 + i; m_sel[i] = 4'hF; m_cti[i] = 3'b000; m_bte[i] = 2'b00;
        end
        s_dat_sm = 32'hDEAD_BEEF; s_ack = 0; s_err = 0; s_rty = 0;
        model_reset();
        tick();
        tick();
        #1;
        check("reset_grant", 64'(grant), 64'(2'b00));
        check("reset_s_cyc", 64'(s_cyc), 64'(1'b0));
        rst_n = 1'b1;
        tick();

        // Single read from master 0, slave answers two cycles after the request edge.
        set_master(0, 1, 1, 3'b000);
        #1 check("t1_pre_s_cyc", 64'(s_cyc), 64'(1'b0));
        tick();
        #1 check("t1_grant", 64'(grant), 64'(2'b01));
        check("t1_s_cyc", 64'(s_cyc), 64'(1'b1));
        tick();
        s_ack = 1;
        #1 check("t1_m0_ack", 64'(m0_ack), 64'(1'b1));
        check("t1_m0_dat", 64'(m0_dat_sm), 64'(32'hDEAD_BEEF));
        check("t1_m1_ack", 64'(m1_ack), 64'(1'b0));
        tick();
        s_ack = 0;
        set_master(0, 0, 0, 3'b000);
        tick();

        // Simultaneous requests after reset: master 0 first, then straight to master 1.
        reset_dut();
        set_master(0, 1, 1, 3'b000);
        set_master(1, 1, 1, 3'b000);
        tick();
        #1 check("t2_grant_first", 64'(grant), 64'(2'b01));
        tick();
        set_master(0, 0, 0, 3'b000);
        #1 check("t2_drop_s_cyc", 64'(s_cyc), 64'(1'b0));
        tick();
        #1 check("t2_grant_next", 64'(grant), 64'(2'b10));
        check("t2_s_cyc", 64'(s_cyc), 64'(1'b1));
        set_master(1, 0, 0, 3'b000);
        tick();

        // Master 1 alone against a silent slave: error on the TIMEOUT-th strobe cycle.
        set_master(1, 1, 1, 3'b000);
        tick();
        for (int i = 1; i <= TIMEOUT; i++) begin
            #1 check("t5_m1_err", 64'(m1_err), 64'(i == TIMEOUT));
            if (i == TIMEOUT) check("t5_s_cyc", 64'(s_cyc), 64'(1'b0));
            tick();
        end
        #1 check("t5_grant_idle", 64'(grant), 64'(2'b00));
        set_master(1, 0, 0, 3'b000);
        tick();

        // Reset asserted between edges during a master 0 burst.
        reset_dut();
        set_master(0, 1, 1, 3'b010);
        tick();
        s_ack = 1;
        tick();
        rst_n = 1'b0;
        model_reset();
        #1 check("t6_s_cyc", 64'(s_cyc), 64'(1'b0));
        check("t6_grant", 64'(grant), 64'(2'b00));
        check("t6_m0_ack", 64'(m0_ack), 64'(1'b0));
        tick();
        rst_n = 1'b1;
        s_ack = 0;
        tick();
        #1 check("t6_regrant", 64'(grant), 64'(2'b01));
        set_master(0, 0, 0, 3'b000);
        tick();

        // Randomized traffic with alternating responsive and silent slave phases.
        dead = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) dead = ($urandom_range(0, 2) == 0);
            if (c == 1500) begin
                rst_n = 1'b0;
                model_reset();
            end else if (c == 1502) begin
                rst_n = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                if (m_cyc[i]) begin
                    if ($urandom_range(0, dead ? 40 : 5) == 0) m_cyc[i] = 0;
                end else if ($urandom_range(0, 3) == 0) begin
                    m_cyc[i] = 1;
                end
                m_stb[i] = m_cyc[i] ? (dead || $urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                m_we[i]  = 1'($urandom);
                m_adr[i] = $urandom;
                m_dat[i] = $urandom;
                m_sel[i] = 4'($urandom);
                case ($urandom_range(0, 2))
                    0:       m_cti[i] = 3'b000;
                    1:       m_cti[i] = 3'b010;
                    default: m_cti[i] = 3'b111;
                endcase
                m_bte[i] = 2'($urandom);
            end
            s_dat_sm = $urandom;
            s_ack = !dead && ($urandom_range(0, 2) == 0);
            s_err = !dead && ($urandom_range(0, 15) == 0);
            s_rty = !dead && ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
